// File: rtl/qbus_demux_bridge.sv
// Bridges a multiplexed Q-bus style core cycle (sync/din/dout on a shared
// address/data bus) onto a demultiplexed request/acknowledge slave bus.
module qbus_demux_bridge #(
  parameter int AW  = 16,
  parameter int TMO = 64
) (
  input  logic          pin_clk,
  input  logic          pin_dclo,
  input  logic          cpu_sync,
  input  logic          cpu_din,
  input  logic          cpu_dout,
  input  logic          cpu_wtbt,
  input  logic          cpu_rmw,
  input  logic [AW-1:0] cpu_ad,
  output logic [15:0]   cpu_rdata,
  output logic          cpu_rply,
  output logic          cpu_berr,
  output logic [AW-1:0] bus_addr,
  output logic [15:0]   bus_wdata,
  output logic [1:0]    bus_be,
  output logic          bus_we,
  output logic          bus_req,
  input  logic [15:0]   bus_rdata,
  input  logic          bus_ack
);

  localparam int CW = (TMO < 2) ? 2 : $clog2(TMO + 1) + 1;
  localparam logic [CW-1:0] TMO_C = CW'(TMO);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_XFER,
    S_REPLY,
    S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic            sync_q;
  logic            wr_cyc_q, wr_cyc_d;
  logic            rmw_cyc_q, rmw_cyc_d;
  logic            rd_done_q, rd_done_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [1:0]      be_q, be_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            rply_q, rply_d;
  logic            berr_q, berr_d;
  logic            sync_rise;
  logic            dout_ok;

  function automatic logic [1:0] byte_en(input logic byte_wr, input logic a0);
    if (!byte_wr) return 2'b11;
    return a0 ? 2'b10 : 2'b01;
  endfunction

  always_comb begin
    state_d   = state_q;
    wr_cyc_d  = wr_cyc_q;
    rmw_cyc_d = rmw_cyc_q;
    rd_done_d = rd_done_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    be_d      = be_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    rply_d    = rply_q;
    berr_d    = berr_q;
    sync_rise = cpu_sync && !sync_q;
    dout_ok   = wr_cyc_q || (rmw_cyc_q && rd_done_q);
    cnt_inc   = cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (sync_rise) begin
          addr_d    = cpu_ad;
          wr_cyc_d  = cpu_wtbt;
          rmw_cyc_d = cpu_rmw;
          rd_done_d = 1'b0;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (cpu_din && cpu_dout) begin
          berr_d  = 1'b1;
          state_d = S_ERR;
        end else if (cpu_din) begin
          we_d    = 1'b0;
          be_d    = 2'b11;
          req_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_XFER;
        end else if (cpu_dout) begin
          if (dout_ok) begin
            wdata_d = cpu_ad[15:0];
            we_d    = 1'b1;
            be_d    = byte_en(cpu_wtbt, addr_q[0]);
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_XFER;
          end else begin
            berr_d  = 1'b1;
            state_d = S_ERR;
          end
        end
      end
      S_XFER: begin
        // cnt_inc is the number of XFER cycles completed including this one,
        // so bus_req stays high for exactly TMO cycles; ack in the last wins.
        if (bus_ack) begin
          req_d   = 1'b0;
          rply_d  = 1'b1;
          if (!we_q) begin
            rdata_d   = bus_rdata;
            rd_done_d = 1'b1;
          end
          state_d = S_REPLY;
        end else if (TMO > 0 && cnt_inc == TMO_C) begin
          req_d   = 1'b0;
          berr_d  = 1'b1;
          state_d = S_ERR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_REPLY: begin
        if (!cpu_din && !cpu_dout) begin
          rply_d  = 1'b0;
          state_d = S_ADDR;
        end
      end
      S_ERR: begin
        req_d  = 1'b0;
        rply_d = 1'b0;
        berr_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Losing sync ends the frame from any state; late slave acks land in IDLE.
    if (state_q != S_IDLE && !cpu_sync) begin
      state_d = S_IDLE;
      req_d   = 1'b0;
      rply_d  = 1'b0;
      berr_d  = 1'b0;
    end
  end

  always_ff @(posedge pin_clk) begin
    // Tracked through reset so a sync held across release is not a rise.
    sync_q <= cpu_sync;
    if (pin_dclo) begin
      state_q   <= S_IDLE;
      wr_cyc_q  <= 1'b0;
      rmw_cyc_q <= 1'b0;
      rd_done_q <= 1'b0;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= 2'b00;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rply_q    <= 1'b0;
      berr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cyc_q  <= wr_cyc_d;
      rmw_cyc_q <= rmw_cyc_d;
      rd_done_q <= rd_done_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      be_q      <= be_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      rply_q    <= rply_d;
      berr_q    <= berr_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_rply  = rply_q;
  assign cpu_berr  = berr_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
  assign bus_we    = we_q;
  assign bus_req   = req_q;

endmodule

// File: tb/tb_qbus_demux_bridge.sv
// Scoreboard bench for qbus_demux_bridge: stimulus queues expected bus
// requests, replies and errors; a negedge monitor pops and compares them.
module tb_qbus_demux_bridge;

  localparam int AW = 22;
  localparam int K_REQ  = 0;
  localparam int K_RPLY = 1;
  localparam int K_BERR = 2;

  logic          clk = 1'b0;
  logic          dclo, sync, din, dout, wtbt, rmw, ack;
  logic [AW-1:0] ad;
  logic [15:0]   brdata;

  logic [15:0]   cpu_rdata, d1_rdata;
  logic          cpu_rply, cpu_berr, d1_rply, d1_berr;
  logic [AW-1:0] bus_addr, d1_addr;
  logic [15:0]   bus_wdata, d1_wdata;
  logic [1:0]    bus_be, d1_be;
  logic          bus_we, bus_req, d1_we, d1_req;

  always #5 clk = ~clk;

  qbus_demux_bridge #(.AW(AW), .TMO(8)) dut (
    .pin_clk(clk), .pin_dclo(dclo), .cpu_sync(sync), .cpu_din(din),
    .cpu_dout(dout), .cpu_wtbt(wtbt), .cpu_rmw(rmw), .cpu_ad(ad),
    .cpu_rdata(cpu_rdata), .cpu_rply(cpu_rply), .cpu_berr(cpu_berr),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_we(bus_we), .bus_req(bus_req), .bus_rdata(brdata), .bus_ack(ack)
  );

  qbus_demux_bridge #(.AW(AW), .TMO(0)) dut_notmo (
    .pin_clk(clk), .pin_dclo(dclo), .cpu_sync(sync), .cpu_din(din),
    .cpu_dout(dout), .cpu_wtbt(wtbt), .cpu_rmw(rmw), .cpu_ad(ad),
    .cpu_rdata(d1_rdata), .cpu_rply(d1_rply), .cpu_berr(d1_berr),
    .bus_addr(d1_addr), .bus_wdata(d1_wdata), .bus_be(d1_be),
    .bus_we(d1_we), .bus_req(d1_req), .bus_rdata(brdata), .bus_ack(ack)
  );

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic          we;
    logic [1:0]    be;
    logic          chk_wd;
    logic [15:0]   wdata;
    logic [15:0]   rdata;
  } exp_t;

  exp_t          sb[$];
  int            n_cmp = 0;
  int            n_err = 0;
  logic [AW-1:0] cur_addr;
  logic [15:0]   last_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every rising edge of bus_req, cpu_rply or cpu_berr consumes one entry.
  initial begin
    logic p_req, p_rply, p_berr;
    exp_t e;
    p_req = 1'b0; p_rply = 1'b0; p_berr = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_req === 1'b1 && p_req !== 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_req: got bus_req rise, want none (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("req_kind", 32'(K_REQ), 32'(e.kind));
          chk("req_addr", 32'(bus_addr), 32'(e.addr));
          chk("req_we", 32'(bus_we), 32'(e.we));
          chk("req_be", 32'(bus_be), 32'(e.be));
          if (e.chk_wd) chk("req_wdata", 32'(bus_wdata), 32'(e.wdata));
        end
      end
      if (cpu_rply === 1'b1 && p_rply !== 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_rply: got cpu_rply rise, want none (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("rply_kind", 32'(K_RPLY), 32'(e.kind));
          chk("rply_rdata", 32'(cpu_rdata), 32'(e.rdata));
        end
      end
      if (cpu_berr === 1'b1 && p_berr !== 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_berr: got cpu_berr rise, want none (t=%0t)", $time);
        end else begin
          e = sb.pop_front();
          chk("berr_kind", 32'(K_BERR), 32'(e.kind));
        end
      end
      p_req = bus_req; p_rply = cpu_rply; p_berr = cpu_berr;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic start_cycle(input logic [AW-1:0] a, input logic w, input logic r);
    step();
    ad = a; wtbt = w; rmw = r; sync = 1'b1; cur_addr = a;
    step();
  endtask

  task automatic end_cycle();
    step();
    sync = 1'b0; din = 1'b0; dout = 1'b0; wtbt = 1'b0; rmw = 1'b0; ad = '0;
    step();
    step();
  endtask

  task automatic wait_req();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus_req === 1'b1) break;
    end
    chk("req_seen", 32'(bus_req), 1);
  endtask

  task automatic pulse_ack(input int dly, input logic [15:0] d);
    repeat (dly) @(posedge clk);
    #1 ack = 1'b1; brdata = d;
    @(posedge clk);
    #1 ack = 1'b0; brdata = '0;
  endtask

  task automatic release_strobe(input logic is_rd);
    repeat (2) @(negedge clk);
    chk("rply_held", 32'(cpu_rply), 1);
    step();
    if (is_rd) din = 1'b0; else dout = 1'b0;
    @(negedge clk);
    chk("rply_held_last", 32'(cpu_rply), 1);
    @(negedge clk);
    chk("rply_drop", 32'(cpu_rply), 0);
  endtask

  task automatic do_read(input logic [15:0] d, input int dly);
    sb.push_back('{K_REQ, cur_addr, 1'b0, 2'b11, 1'b0, 16'h0, 16'h0});
    sb.push_back('{K_RPLY, cur_addr, 1'b0, 2'b00, 1'b0, 16'h0, d});
    last_rd = d;
    step();
    din = 1'b1;
    wait_req();
    pulse_ack(dly, d);
    @(negedge clk);
    chk("rd_rply_lat", 32'(cpu_rply), 1);
    chk("rd_req_drop", 32'(bus_req), 0);
    chk("rd_rdata", 32'(cpu_rdata), 32'(d));
    release_strobe(1'b1);
  endtask

  task automatic do_write(input logic [15:0] d, input logic bytew, input logic [1:0] be);
    sb.push_back('{K_REQ, cur_addr, 1'b1, be, 1'b1, d, 16'h0});
    sb.push_back('{K_RPLY, cur_addr, 1'b0, 2'b00, 1'b0, 16'h0, last_rd});
    step();
    ad = {{(AW-16){1'b0}}, d}; wtbt = bytew; dout = 1'b1;
    wait_req();
    pulse_ack(1, 16'h0);
    @(negedge clk);
    chk("wr_rply_lat", 32'(cpu_rply), 1);
    chk("wr_req_drop", 32'(bus_req), 0);
    chk("wr_rdata_kept", 32'(cpu_rdata), 32'(last_rd));
    release_strobe(1'b0);
  endtask

  task automatic err_frame(input logic di, input logic dq);
    sb.push_back('{K_BERR, cur_addr, 1'b0, 2'b00, 1'b0, 16'h0, 16'h0});
    step();
    ad = 22'h000BAD; din = di; dout = dq;
    repeat (2) @(negedge clk);
    chk("err_berr", 32'(cpu_berr), 1);
    chk("err_req", 32'(bus_req), 0);
    chk("err_rply", 32'(cpu_rply), 0);
    step();
    din = 1'b0; dout = 1'b0; sync = 1'b0;
    @(negedge clk);
    chk("err_hold", 32'(cpu_berr), 1);
    @(negedge clk);
    chk("err_clear", 32'(cpu_berr), 0);
  endtask

  task automatic rst_check();
    chk("rst_ctl", 32'({bus_req, bus_we, bus_be, cpu_rply, cpu_berr}), 0);
    chk("rst_addr", 32'(bus_addr), 0);
    chk("rst_wdata", 32'(bus_wdata), 0);
    chk("rst_rdata", 32'(cpu_rdata), 0);
    chk("rst_ctl_notmo", 32'({d1_req, d1_we, d1_be, d1_rply, d1_berr}), 0);
    chk("rst_data_notmo", 32'(d1_addr) | 32'(d1_wdata) | 32'(d1_rdata), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    dclo = 1'b1; sync = 1'b0; din = 1'b0; dout = 1'b0; wtbt = 1'b0; rmw = 1'b0;
    ack = 1'b0; brdata = '0; ad = '0; cur_addr = '0; last_rd = '0;
    repeat (3) @(posedge clk);
    #1 dclo = 1'b0;
    @(negedge clk);
    rst_check();

    // Plain read, ack a few cycles after request
    start_cycle(22'h001234, 1'b0, 1'b0);
    do_read(16'hBEEF, 3);
    end_cycle();

    // Byte writes to odd/even address, then a full word write
    start_cycle(22'h001001, 1'b1, 1'b0);
    do_write(16'h00A5, 1'b1, 2'b10);
    end_cycle();
    start_cycle(22'h001002, 1'b1, 1'b0);
    do_write(16'h005A, 1'b1, 2'b01);
    end_cycle();
    start_cycle(22'h001004, 1'b1, 1'b0);
    do_write(16'hA55A, 1'b0, 2'b11);
    end_cycle();

    // Read-modify-write in one frame
    start_cycle(22'h002000, 1'b0, 1'b1);
    do_read(16'h1357, 1);
    do_write(16'h5555, 1'b0, 2'b11);
    end_cycle();

    // Full 22-bit address, immediate ack
    start_cycle(22'h3FFFFE, 1'b0, 1'b0);
    do_read(16'h0F0F, 0);
    end_cycle();

    // Ack in the 8th XFER cycle, same cycle the timeout would fire
    start_cycle(22'h000042, 1'b0, 1'b0);
    do_read(16'h7777, 7);
    end_cycle();

    // Protocol errors: dout in read cycle, din+dout, RMW write before read
    start_cycle(22'h000100, 1'b0, 1'b0);
    err_frame(1'b0, 1'b1);
    end_cycle();
    start_cycle(22'h000102, 1'b1, 1'b0);
    err_frame(1'b1, 1'b1);
    end_cycle();
    start_cycle(22'h000104, 1'b0, 1'b1);
    err_frame(1'b0, 1'b1);
    end_cycle();

    // Timeout with TMO=8; the TMO=0 instance keeps waiting
    start_cycle(22'h000040, 1'b0, 1'b0);
    sb.push_back('{K_REQ, cur_addr, 1'b0, 2'b11, 1'b0, 16'h0, 16'h0});
    sb.push_back('{K_BERR, cur_addr, 1'b0, 2'b00, 1'b0, 16'h0, 16'h0});
    step();
    din = 1'b1;
    wait_req();
    n = 0;
    while (bus_req === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("tmo_cycles", 32'(n), 8);
    chk("tmo_berr", 32'(cpu_berr), 1);
    chk("tmo_no_rply", 32'(cpu_rply), 0);
    repeat (20) @(negedge clk);
    chk("tmo0_req_wait", 32'(d1_req), 1);
    chk("tmo0_no_berr", 32'(d1_berr), 0);
    chk("tmo_berr_hold", 32'(cpu_berr), 1);
    pulse_ack(0, 16'h4444);
    @(negedge clk);
    chk("tmo0_rply", 32'(d1_rply), 1);
    chk("tmo0_rdata", 32'(d1_rdata), 32'h4444);
    chk("tmo_late_ack_ignored", 32'(cpu_rply), 0);
    step();
    din = 1'b0; sync = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("tmo_berr_clear", 32'(cpu_berr), 0);
    end_cycle();

    // Reset during XFER, with sync held through release
    start_cycle(22'h000ABC, 1'b0, 1'b0);
    sb.push_back('{K_REQ, cur_addr, 1'b0, 2'b11, 1'b0, 16'h0, 16'h0});
    step();
    din = 1'b1;
    wait_req();
    step();
    dclo = 1'b1;
    step();
    dclo = 1'b0;
    @(negedge clk);
    rst_check();
    last_rd = '0;
    repeat (4) @(negedge clk);
    chk("held_sync_no_req", 32'(bus_req), 0);
    step();
    din = 1'b0;
    step();
    din = 1'b1;
    repeat (3) @(negedge clk);
    chk("held_sync_din_no_req", 32'(bus_req), 0);
    end_cycle();
    start_cycle(22'h000ABC, 1'b0, 1'b0);
    do_read(16'hCAFE, 2);
    end_cycle();

    chk("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/qbus_demux_bridge.md
QBUS_DEMUX_BRIDGE -- requirements
Module: qbus_demux_bridge

Interface
REQ-001 Parameter AW, default 16: width of latched address, range 16..22.
REQ-002 Parameter TMO, default 64: max cycles bus_req waits for bus_ack before bus error; 0 disables timeout.
REQ-003 pin_clk  in  1  sole clock; all logic on rising edge.
REQ-004 pin_dclo  in  1  reset, synchronous, active-high.
REQ-005 cpu_sync  in  1  core address strobe; cycle framed by sync high.
REQ-006 cpu_din  in  1  core read data strobe.
REQ-007 cpu_dout  in  1  core write data strobe.
REQ-008 cpu_wtbt  in  1  at sync rise: write cycle; at dout: byte write.
REQ-009 cpu_rmw  in  1  at sync rise: read-modify-write cycle.
REQ-010 cpu_ad  in  AW  address at sync rise; write data in bits [15:0] while dout.
REQ-011 cpu_rdata  out  16  read data to core.
REQ-012 cpu_rply  out  1  transfer reply to core.
REQ-013 cpu_berr  out  1  bus timeout/protocol error flag.
REQ-014 bus_addr  out  AW  demultiplexed address.
REQ-015 bus_wdata  out  16  write data.
REQ-016 bus_be  out  2  byte enables, [0] low byte, [1] high byte.
REQ-017 bus_we  out  1  write qualifier, valid with bus_req.
REQ-018 bus_req  out  1  slave transfer request.
REQ-019 bus_rdata  in  16  slave read data, valid with bus_ack.
REQ-020 bus_ack  in  1  one-cycle slave completion.

Function
REQ-021 FSM states: IDLE, ADDR, XFER, REPLY, ERR.
REQ-022 Sync rise = cpu_sync high while previous-cycle sync low; in IDLE: latch bus_addr<=cpu_ad, wr_cyc<=cpu_wtbt, rmw_cyc<=cpu_rmw, clear rd_done; go ADDR.
REQ-023 ADDR, din only: bus_we=0, bus_be=11, bus_req=1 next cycle; go XFER.
REQ-024 ADDR, dout only: bus_wdata<=cpu_ad[15:0], bus_we=1; bus_be = cpu_wtbt ? (bus_addr[0] ? 10 : 01) : 11; bus_req=1 next cycle; go XFER.
REQ-025 dout accepted only if wr_cyc, or rmw_cyc with rd_done set; otherwise ERR.
REQ-026 ADDR with din and dout both high: ERR.
REQ-027 XFER: bus_req, bus_addr, bus_wdata, bus_be, bus_we held stable until bus_ack or timeout.
REQ-028 XFER, bus_ack: drop bus_req next edge; on read capture cpu_rdata<=bus_rdata and set rd_done; cpu_rply=1 next edge; go REPLY.
REQ-029 Latency: ack at cycle M -> cpu_rply and cpu_rdata valid at M+1.
REQ-030 REPLY: hold cpu_rply until din and dout both low, then cpu_rply=0, go ADDR if sync high, else IDLE.
REQ-031 Timeout counter clears on XFER entry, increments each XFER cycle without ack; at count==TMO (TMO>0): bus_req=0, cpu_berr=1, go ERR, no cpu_rply.
REQ-032 bus_ack in same cycle as count==TMO: ack wins, no error.
REQ-033 ERR: cpu_berr held 1, bus_req 0, cpu_rply 0 until cpu_sync low; then cpu_berr=0, go IDLE.
REQ-034 Sync fall in any state: bus_req=0, cpu_rply=0, go IDLE next edge; an in-flight slave ack after that is ignored.
REQ-035 RMW: read then write within one sync frame; bus_addr unchanged between phases.
REQ-036 bus_addr, bus_be, bus_wdata keep last value in IDLE; only bus_req qualifies them.

Reset
REQ-037 pin_dclo high at an edge: state IDLE, bus_req=0, bus_we=0, bus_be=00, bus_addr=0, bus_wdata=0, cpu_rdata=0, cpu_rply=0, cpu_berr=0, counter=0, rd_done=0, wr_cyc=0, rmw_cyc=0.
REQ-038 Reset mid-transfer aborts immediately; bus_req low the cycle after reset sampled; reset dominates all events.
REQ-039 After pin_dclo low, a new cycle requires a fresh sync rise; sync already high at reset release is ignored until it falls.

Verification
REQ-040 Read: sync with ad=0x1234, din, ack 3 cycles later with rdata=0xBEEF -> bus_addr=0x1234, bus_we=0, be=11, cpu_rdata=0xBEEF, cpu_rply one cycle after ack, held until din low.
REQ-041 Byte write: sync ad=0x1001 wtbt=1, dout wtbt=1 ad=0x00A5 -> bus_we=1, be=10, wdata=0x00A5, rply after ack.
REQ-042 RMW: sync ad=0x2000 rmw=1 wtbt=0, din/ack, then dout 0x5555 -> two bus_req, second with bus_we=1, same addr, two rply pulses.
REQ-043 Timeout TMO=8: read, no ack -> bus_req drops after 8 XFER cycles, cpu_berr=1 until sync low, no rply; TMO=0 -> waits indefinitely.
REQ-044 AW=22: ad=0x3FFFFE -> bus_addr=0x3FFFFE; dout in a non-write, non-RMW cycle -> cpu_berr=1.
REQ-045 pin_dclo asserted during XFER -> all outputs at reset values next cycle; held sync ignored until it falls.
